obi_rr_arbiter: RTL

OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

---
 rtl/obi_rr_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter folding NUM_REQ OBI requesters onto one manager port.
// Only one transaction can be outstanding at a time.
module obi_rr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int OBI_ADDRW = 32,
    parameter int OBI_DATAW = 32,
    localparam int OBI_STRBW = OBI_DATAW / 8,
    localparam int IDXW      = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           arst_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*OBI_ADDRW-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ*OBI_DATAW-1:0]   wdata_i,
    input  logic [NUM_REQ*OBI_STRBW-1:0]   be_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [OBI_DATAW-1:0]           rdata_o,
    output logic                           m_req_o,
    output logic [OBI_ADDRW-1:0]           m_addr_o,
    output logic                           m_we_o,
    output logic [OBI_DATAW-1:0]           m_wdata_o,
    output logic [OBI_STRBW-1:0]           m_be_o,
    input  logic                           m_gnt_i,
    input  logic                           m_rvalid_i,
    input  logic [OBI_DATAW-1:0]           m_rdata_i,
    output logic                           busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [IDXW-1:0] owner_q;
    logic [IDXW-1:0] last_q;
    logic [IDXW-1:0] winner;
    logic [IDXW-1:0] idx;

    // Scan from the farthest offset down so the nearest asserted index wins.
    always_comb begin
        winner = last_q;
        idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDXW'((int'(last_q) + i) % NUM_REQ);
            if (req_i[idx]) begin
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDXW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req_i) begin
                owner_q <= winner;
            end
            if (state_q == REQ && m_gnt_i) begin
                last_q <= owner_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (m_gnt_i) begin
                    state_d = m_rvalid_i ? IDLE : RESP;
                end
            end
            RESP: begin
                if (m_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o     = '0;
        rvalid_o  = '0;
        m_req_o   = 1'b0;
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_wdata_o = '0;
        m_be_o    = '0;
        busy_o    = (state_q != IDLE);
        rdata_o   = m_rdata_i;
        if (state_q == REQ) begin
            m_req_o   = 1'b1;
            m_addr_o  = addr_i[int'(owner_q)*OBI_ADDRW +: OBI_ADDRW];
            m_we_o    = we_i[owner_q];
            m_wdata_o = wdata_i[int'(owner_q)*OBI_DATAW +: OBI_DATAW];
            m_be_o    = be_i[int'(owner_q)*OBI_STRBW +: OBI_STRBW];
            if (m_gnt_i) begin
                gnt_o[owner_q]    = 1'b1;
                rvalid_o[owner_q] = m_rvalid_i;
            end
        end
        if (state_q == RESP) begin
            rvalid_o[owner_q] = m_rvalid_i;
        end
    end

endmodule
